hazard_unit: RTL and testbench

Pipeline hazard unit for the five-stage ARM core. It sits beside the pipelined controller and consumes its per-stage control bits (PCSrcD/E/M/W, RegWrite, MemToRegE, BranchTakenE, LongE) together with the datapath register numbers. It produces the stall, flush and forwarding selects that drive the controller's and datapath's pipeline registers. It also holds a small FSM that freezes the front of the pipeline while a multi-cycle long multiply occupies Execute, plus two saturating event counters for performance debug.

---
 rtl/hazard_unit.sv | 161 ++++++++++++++++
 tb/tb_hazard_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit -- stall/flush/forward control for the five-stage ARM pipeline.
//
// Combinational hazard detection (forwarding, load-use, PC-writing
// instructions, taken branches), a two-state FSM that freezes F/D/E while
// a multi-cycle long op sits in Execute, and two saturating event counters.
//
// Ports
//   clk, reset                 : rising-edge clock, async active-low reset
//   RA1D/RA2D, RA1E/RA2E       : source registers in Decode / Execute
//   WA3E/WA3M/WA3W, RegWrite*  : destination registers and write enables
//   MemToRegE                  : load in Execute
//   PCSrcD/E/M/W, BranchTakenE : PC-writing instructions, taken branch
//   LongE                      : long (multi-cycle) op in Execute
//   CntClear                   : synchronous clear of both counters
//   ForwardAE/BE               : 00 regfile, 01 ResultW, 10 ALUOutM
//   StallF/D/E, FlushD/E       : pipeline register controls
//   LongBusy                   : long-op freeze active
//   StallCount, FlushCount     : saturating event counters

// Per-operand forwarding select; Memory wins over Writeback.
module hazardFwdSel (
  input  logic [3:0] raE,
  input  logic [3:0] wa3M,
  input  logic [3:0] wa3W,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] fwd
);
  always_comb begin
    fwd = 2'b00;
    if (regWriteM && raE == wa3M)      fwd = 2'b10;
    else if (regWriteW && raE == wa3W) fwd = 2'b01;
  end
endmodule

module hazard_unit #(
  parameter int LONG_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             LongE,
  input  logic             CntClear,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             LongBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  localparam int CW = $clog2(LONG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- forwarding, one select per source operand
  logic [1:0][3:0] raE;
  logic [1:0][1:0] fwdE;
  assign raE = {RA2E, RA1E};

  for (genvar i = 0; i < 2; i++) begin : gFwd
    hazardFwdSel uFwd (
      .raE       (raE[i]),
      .wa3M      (WA3M),
      .wa3W      (WA3W),
      .regWriteM (RegWriteM),
      .regWriteW (RegWriteW),
      .fwd       (fwdE[i])
    );
  end
  assign ForwardAE = fwdE[0];
  assign ForwardBE = fwdE[1];

  // ---------------- load-use and PC hazards
  logic ldrStall, pcPending;
  assign ldrStall  = MemToRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcPending = PCSrcD | PCSrcE | PCSrcM;

  // ---------------- long-op FSM
  // The entry cycle already stalls, so cnt is loaded with N-2 to give
  // N-1 stall cycles followed by the cycle in which the op advances.
  typedef enum logic {IDLE, LONG} longState_t;
  longState_t      state, stateNext;
  logic [CW-1:0]   cnt, cntNext;
  logic            longStallRaw, longStall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    longStallRaw = 1'b0;
    case (state)
      IDLE: if (LongE) begin
        longStallRaw = 1'b1;
        stateNext    = LONG;
        cntNext      = CW'(LONG_CYCLES - 2);
      end
      LONG: if (cnt != '0) begin
        longStallRaw = 1'b1;
        cntNext      = cnt - CW'(1);
      end else begin
        stateNext    = IDLE;
      end
    endcase
  end

  // Gate with reset so the freeze drops the moment reset asserts, even if
  // LongE is still high from the interrupted op.
  assign longStall = reset & longStallRaw;
  assign LongBusy  = longStall;

  // ---------------- stall / flush; the long freeze protects its victims
  assign StallF = ldrStall | pcPending | longStall;
  assign StallD = ldrStall | longStall;
  assign StallE = longStall;
  assign FlushD = ~longStall & (pcPending | PCSrcW | BranchTakenE);
  assign FlushE = ~longStall & (ldrStall | BranchTakenE);

  // ---------------- saturating event counters, clear has priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (CntClear) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && StallCount != CNT_MAX)
        StallCount <= StallCount + CNT_W'(1);
      if ((FlushD || FlushE) && FlushCount != CNT_MAX)
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int MAXC = 15;

  logic clk, reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemToRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE, CntClear;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, LongBusy;
  logic [CW-1:0] StallCount, FlushCount;

  hazard_unit #(.LONG_CYCLES(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .LongE(LongE), .CntClear(CntClear),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .LongBusy(LongBusy),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: phase = which cycle (1..N) of a long op sits in E,
  // 0 when none; counts are plain integers clamped at MAXC.
  int phase = 0;
  int mStall = 0;
  int mFlush = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemToRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, LongE, CntClear} = '0;
  endtask

  function automatic logic [1:0] fwdRef(input logic [3:0] ra);
    if (RegWriteM && ra == WA3M) return 2'b10;
    if (RegWriteW && ra == WA3W) return 2'b01;
    return 2'b00;
  endfunction

  // Check every output against the model mid-cycle, then advance the model
  // across the rising edge. Inputs are expected to be stable already.
  task automatic tick();
    int eff;
    bit lng, ldr, pcp, sF, fD, fE;
    @(negedge clk);
    if (!reset) begin phase = 0; mStall = 0; mFlush = 0; end
    eff = (phase == 0) ? (LongE ? 1 : 0) : phase;
    lng = reset && eff >= 1 && eff <= N - 1;
    ldr = MemToRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
    pcp = PCSrcD || PCSrcE || PCSrcM;
    sF  = ldr || pcp || lng;
    fD  = !lng && (pcp || PCSrcW || BranchTakenE);
    fE  = !lng && (ldr || BranchTakenE);
    chk("ForwardAE", ForwardAE, fwdRef(RA1E));
    chk("ForwardBE", ForwardBE, fwdRef(RA2E));
    chk("StallF", StallF, sF);
    chk("StallD", StallD, ldr || lng);
    chk("StallE", StallE, lng);
    chk("FlushD", FlushD, fD);
    chk("FlushE", FlushE, fE);
    chk("LongBusy", LongBusy, lng);
    chk("StallCount", StallCount, mStall);
    chk("FlushCount", FlushCount, mFlush);
    @(posedge clk);
    if (!reset) begin
      phase = 0; mStall = 0; mFlush = 0;
    end else begin
      phase = (eff == 0 || eff == N) ? 0 : eff + 1;
      if (CntClear) begin mStall = 0; mFlush = 0; end
      else begin
        if (sF && mStall < MAXC) mStall++;
        if ((fD || fE) && mFlush < MAXC) mFlush++;
      end
    end
    #1;
  endtask

  initial begin
    clr();
    reset = 1'b0;
    // reset with all inputs low: every output zero
    tick();
    chk("rstStallF", StallF, 0);
    chk("rstFlushD", FlushD, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // forwarding
    RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1; #1;
    chk("fwdM", ForwardAE, 2'b10);
    tick();
    RegWriteM = 0; RA2E = 5; #1;
    chk("fwdW", ForwardAE, 2'b01);
    chk("fwdNone", ForwardBE, 2'b00);
    tick();

    // load-use, one cycle
    clr(); MemToRegE = 1; RegWriteE = 1; WA3E = 2; RA2D = 2; RA1D = 7; #1;
    chk("ldStallF", StallF, 1);
    chk("ldStallD", StallD, 1);
    chk("ldFlushE", FlushE, 1);
    chk("ldFlushD", FlushD, 0);
    tick();
    clr(); tick();

    // taken branch
    BranchTakenE = 1; #1;
    chk("brFlushD", FlushD, 1);
    chk("brFlushE", FlushE, 1);
    chk("brStallF", StallF, 0);
    tick();

    // PC write travelling D -> E -> M -> W
    for (int i = 0; i < 4; i++) begin
      clr();
      PCSrcD = (i == 0); PCSrcE = (i == 1); PCSrcM = (i == 2); PCSrcW = (i == 3); #1;
      chk("pcStallF", StallF, i < 3);
      chk("pcFlushD", FlushD, 1);
      tick();
    end

    // single long op, branch inside the freeze must not flush
    clr(); LongE = 1;
    for (int i = 0; i < N; i++) begin
      BranchTakenE = (i == 1); #1;
      chk("longBusy", LongBusy, i < N - 1);
      chk("longStallD", StallD, i < N - 1);
      if (i == 1) chk("longNoFlushD", FlushD, 0);
      tick();
    end

    // back-to-back long ops: 3 busy, 1 free, 3 busy, 1 free
    clr(); LongE = 1;
    for (int i = 0; i < 2 * N; i++) begin
      #1; chk("b2bBusy", LongBusy, (i % N) != N - 1);
      tick();
    end
    clr(); tick();

    // reset during cycle 2 of a long op
    LongE = 1; tick();
    reset = 1'b0; #1;
    chk("rstLongBusy", LongBusy, 0);
    chk("rstStallCnt", StallCount, 0);
    chk("rstFlushCnt", FlushCount, 0);
    tick();
    LongE = 0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("postRstIdle", LongBusy, 0);
      tick();
    end

    // saturation and clear priority
    clr(); PCSrcD = 1;
    repeat (20) tick();
    chk("satStall", StallCount, MAXC);
    CntClear = 1; tick();
    chk("clrStall", StallCount, 0);
    clr(); tick();

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemToRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      LongE = ($urandom_range(0, 3) == 0);
      CntClear = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
